// File: rtl/isu_issue_queue_pkg.sv
// isu_issue_queue_pkg: cache op encodings, load/store classification and refill-op conversion
package isu_issue_queue_pkg;
  localparam int OP_W = 3;
  typedef enum logic [OP_W-1:0] {
    CACHE_OP_LOAD         = 3'd0,
    CACHE_OP_STORE        = 3'd1,
    CACHE_OP_LOAD_REFILL  = 3'd2,
    CACHE_OP_STORE_REFILL = 3'd3,
    CACHE_OP_FLUSH        = 3'd4,
    CACHE_OP_INVAL        = 3'd5
  } cache_op_e;
  function automatic logic is_load(logic [OP_W-1:0] op);
    return op == CACHE_OP_LOAD || op == CACHE_OP_LOAD_REFILL;
  endfunction
  function automatic logic is_store(logic [OP_W-1:0] op);
    return op == CACHE_OP_STORE || op == CACHE_OP_STORE_REFILL;
  endfunction
  function automatic logic [OP_W-1:0] to_refill_op(logic [OP_W-1:0] op);
    return is_load(op) ? CACHE_OP_LOAD_REFILL : is_store(op) ? CACHE_OP_STORE_REFILL : op;
  endfunction
endpackage

// File: rtl/isu_issue_queue_if.sv
// isu_issue_queue_if: enq/wake/credit inputs and issue/release outputs; master drives requests, slave is the queue
interface isu_issue_queue_if
  import isu_issue_queue_pkg::*;
#(
  parameter int NumCh  = 3,
  parameter int NlineW = 10,
  parameter int SetW   = 6,
  parameter int WbufW  = 4,
  parameter int RobW   = 4
);
  logic                   enq_valid;
  logic                   enq_ready;
  logic [NumCh-1:0]       enq_ch_1hot;
  logic [OP_W-1:0]        enq_op;
  logic [NlineW-1:0]      enq_id;
  logic [WbufW-1:0]       enq_wbuf_id;
  logic                   enq_inflight;
  logic                   wake_valid;
  logic [NlineW-1:0]      wake_id;
  logic [NumCh-1:0]       crdt_rtn;
  logic                   d_valid;
  logic                   d_ready;
  logic [NumCh-1:0]       d_ch_1hot;
  logic [RobW-1:0]        d_rob_id;
  logic [OP_W-1:0]        d_op;
  logic [SetW-1:0]        d_set;
  logic [NlineW-SetW-1:0] d_way;
  logic [WbufW-1:0]       d_wbuf_id;
  logic                   rel_valid;
  logic [NlineW-1:0]      rel_id;
  modport master (
    output enq_valid, enq_ch_1hot, enq_op, enq_id, enq_wbuf_id, enq_inflight, wake_valid, wake_id, crdt_rtn, d_ready,
    input  enq_ready, d_valid, d_ch_1hot, d_rob_id, d_op, d_set, d_way, d_wbuf_id, rel_valid, rel_id
  );
  modport slave (
    input  enq_valid, enq_ch_1hot, enq_op, enq_id, enq_wbuf_id, enq_inflight, wake_valid, wake_id, crdt_rtn, d_ready,
    output enq_ready, d_valid, d_ch_1hot, d_rob_id, d_op, d_set, d_way, d_wbuf_id, rel_valid, rel_id
  );
endinterface

// File: rtl/isu_issue_queue_age.sv
// isu_age_matrix: row i holds entries older than i (set on alloc, column cleared on free); oldest = one-hot oldest requester
module isu_age_matrix
  import isu_issue_queue_pkg::*;
#(
  parameter int Depth = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [Depth-1:0] vld,
  input  logic [Depth-1:0] alloc,
  input  logic [Depth-1:0] free,
  input  logic [Depth-1:0] req,
  output logic [Depth-1:0] oldest
);
  logic [Depth-1:0] older_q [Depth];
  logic [Depth-1:0] older_d [Depth];
  always_comb begin
    for (int i = 0; i < Depth; i++) oldest[i] = req[i] & ~|(older_q[i] & req);
  end
  always_comb begin
    for (int i = 0; i < Depth; i++) older_d[i] = alloc[i] ? vld & ~free : older_q[i] & ~free;
  end
  always_ff @(posedge clk) begin
    if (rst) for (int i = 0; i < Depth; i++) older_q[i] <= '0;
    else older_q <= older_d;
  end
endmodule

// File: rtl/isu_issue_queue.sv
// isu_issue_queue: oldest-first issue queue with per-channel ROB credits, refill wakeup and line release (clk, rst, q: slave modport of isu_issue_queue_if)
module isu_issue_queue
  import isu_issue_queue_pkg::*;
#(
  parameter int NumCh    = 3,
  parameter int Depth    = 8,
  parameter int RobDepth = 16,
  parameter int NlineW   = 10,
  parameter int SetW     = 6,
  parameter int WbufW    = 4
) (
  input logic              clk,
  input logic              rst,
  isu_issue_queue_if.slave q
);
  localparam int RobW = $clog2(RobDepth);
  localparam int CrW  = $clog2(RobDepth + 1);
  localparam int IdxW = $clog2(Depth);
  logic [Depth-1:0]       valid_q, valid_d, wait_q, wait_d, refill_q, refill_d;
  logic [NumCh-1:0]       ch_q [Depth];
  logic [NumCh-1:0]       ch_d [Depth];
  logic [OP_W-1:0]        op_q [Depth];
  logic [OP_W-1:0]        op_d [Depth];
  logic [NlineW-1:0]      id_q [Depth];
  logic [NlineW-1:0]      id_d [Depth];
  logic [WbufW-1:0]       wbuf_q [Depth];
  logic [WbufW-1:0]       wbuf_d [Depth];
  logic [CrW-1:0]         credit_q [NumCh];
  logic [CrW-1:0]         credit_d [NumCh];
  logic [RobW-1:0]        rob_ptr_q [NumCh];
  logic [RobW-1:0]        rob_ptr_d [NumCh];
  logic                   d_valid_q, d_valid_d, rel_valid_q, rel_valid_d;
  logic [NumCh-1:0]       d_ch_q, d_ch_d;
  logic [RobW-1:0]        d_rob_id_q, d_rob_id_d, rob_sel;
  logic [OP_W-1:0]        d_op_q, d_op_d;
  logic [SetW-1:0]        d_set_q, d_set_d;
  logic [NlineW-SetW-1:0] d_way_q, d_way_d;
  logic [WbufW-1:0]       d_wbuf_q, d_wbuf_d;
  logic [NlineW-1:0]      rel_id_q, rel_id_d;
  logic [Depth-1:0]       alloc, free, elig, sel, wake_hit;
  logic [NumCh-1:0]       ch_ok, dec;
  logic [IdxW-1:0]        alloc_idx, sel_idx;
  logic                   enq_fire, enq_wake, load;
  always_comb begin
    enq_fire = q.enq_valid & ~&valid_q;
    alloc_idx = '0;
    for (int i = Depth - 1; i >= 0; i--) if (!valid_q[i]) alloc_idx = IdxW'(i);
    alloc = enq_fire ? Depth'(1) << alloc_idx : '0;
    for (int c = 0; c < NumCh; c++) ch_ok[c] = credit_q[c] != '0;
    for (int i = 0; i < Depth; i++) elig[i] = valid_q[i] & ~wait_q[i] & |(ch_q[i] & ch_ok);
    load = (~d_valid_q | q.d_ready) & |elig;
  end
  isu_age_matrix #(.Depth(Depth)) u_age (
    .clk(clk), .rst(rst), .vld(valid_q), .alloc(alloc), .free(free), .req(elig), .oldest(sel)
  );
  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < Depth; i++) if (sel[i]) sel_idx = IdxW'(i);
    free = load ? sel : '0;
    dec = load ? ch_q[sel_idx] : '0;
    rob_sel = '0;
    for (int c = 0; c < NumCh; c++) if (ch_q[sel_idx][c]) rob_sel = rob_ptr_q[c];
    enq_wake = q.wake_valid & (q.wake_id == q.enq_id);
    valid_d = (valid_q & ~free) | alloc;
    for (int i = 0; i < Depth; i++) begin
      wake_hit[i] = valid_q[i] & wait_q[i] & q.wake_valid & (id_q[i] == q.wake_id);
      ch_d[i]     = alloc[i] ? q.enq_ch_1hot : ch_q[i];
      op_d[i]     = alloc[i] ? q.enq_op : op_q[i];
      id_d[i]     = alloc[i] ? q.enq_id : id_q[i];
      wbuf_d[i]   = alloc[i] ? q.enq_wbuf_id : wbuf_q[i];
      wait_d[i]   = alloc[i] ? q.enq_inflight & ~enq_wake : wait_q[i] & ~wake_hit[i];
      refill_d[i] = alloc[i] ? q.enq_inflight & enq_wake : refill_q[i] | wake_hit[i];
    end
    for (int c = 0; c < NumCh; c++) begin
      credit_d[c]  = credit_q[c] - CrW'(dec[c]) + CrW'(q.crdt_rtn[c]);
      rob_ptr_d[c] = rob_ptr_q[c] + RobW'(dec[c]);
    end
    d_valid_d   = load | (d_valid_q & ~q.d_ready);
    d_ch_d      = load ? ch_q[sel_idx] : d_ch_q;
    d_rob_id_d  = load ? rob_sel : d_rob_id_q;
    d_op_d      = load ? (refill_q[sel_idx] ? to_refill_op(op_q[sel_idx]) : op_q[sel_idx]) : d_op_q;
    d_set_d     = load ? id_q[sel_idx][SetW-1:0] : d_set_q;
    d_way_d     = load ? id_q[sel_idx][NlineW-1:SetW] : d_way_q;
    d_wbuf_d    = load ? wbuf_q[sel_idx] : d_wbuf_q;
    rel_valid_d = d_valid_q & q.d_ready;
    rel_id_d    = rel_valid_d ? {d_way_q, d_set_q} : rel_id_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= '0;
      wait_q      <= '0;
      refill_q    <= '0;
      for (int i = 0; i < Depth; i++) begin
        ch_q[i]   <= '0;
        op_q[i]   <= '0;
        id_q[i]   <= '0;
        wbuf_q[i] <= '0;
      end
      for (int c = 0; c < NumCh; c++) begin
        credit_q[c]  <= CrW'(RobDepth);
        rob_ptr_q[c] <= '0;
      end
      d_valid_q   <= 1'b0;
      d_ch_q      <= '0;
      d_rob_id_q  <= '0;
      d_op_q      <= '0;
      d_set_q     <= '0;
      d_way_q     <= '0;
      d_wbuf_q    <= '0;
      rel_valid_q <= 1'b0;
      rel_id_q    <= '0;
    end else begin
      valid_q     <= valid_d;
      wait_q      <= wait_d;
      refill_q    <= refill_d;
      ch_q        <= ch_d;
      op_q        <= op_d;
      id_q        <= id_d;
      wbuf_q      <= wbuf_d;
      credit_q    <= credit_d;
      rob_ptr_q   <= rob_ptr_d;
      d_valid_q   <= d_valid_d;
      d_ch_q      <= d_ch_d;
      d_rob_id_q  <= d_rob_id_d;
      d_op_q      <= d_op_d;
      d_set_q     <= d_set_d;
      d_way_q     <= d_way_d;
      d_wbuf_q    <= d_wbuf_d;
      rel_valid_q <= rel_valid_d;
      rel_id_q    <= rel_id_d;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!q.enq_valid || $onehot(q.enq_ch_1hot));
      assert (!(q.enq_valid && !q.enq_ready));
      for (int c = 0; c < NumCh; c++) assert (credit_q[c] <= CrW'(RobDepth));
    end
  end
  assign q.enq_ready = ~&valid_q;
  assign q.d_valid   = d_valid_q;
  assign q.d_ch_1hot = d_ch_q;
  assign q.d_rob_id  = d_rob_id_q;
  assign q.d_op      = d_op_q;
  assign q.d_set     = d_set_q;
  assign q.d_way     = d_way_q;
  assign q.d_wbuf_id = d_wbuf_q;
  assign q.rel_valid = rel_valid_q;
  assign q.rel_id    = rel_id_q;
endmodule

// File: tb/tb_isu_issue_queue.sv
// tb_isu_issue_queue: directed stimulus with an age-ordered queue model compared every cycle plus literal spot checks
module tb_isu_issue_queue;
  import isu_issue_queue_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  isu_issue_queue_if #(.NumCh(3), .NlineW(10), .SetW(6), .WbufW(4), .RobW(4)) bus ();
  isu_issue_queue #(.NumCh(3), .Depth(8), .RobDepth(16), .NlineW(10), .SetW(6), .WbufW(4)) dut (
    .clk(clk), .rst(rst), .q(bus)
  );
  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  typedef struct {
    int         ch;
    logic [2:0] op;
    logic [9:0] id;
    logic [3:0] wb;
    bit         wt;
    bit         rf;
  } ent_t;
  ent_t       mq[$];
  ent_t       ne;
  int         m_cr[3];
  int         m_rob[3];
  bit         m_dv, m_rv, macc, mld;
  int         mk, mch;
  logic [2:0] m_dch, m_dop;
  logic [3:0] m_drob, m_dwb;
  logic [9:0] m_did, m_rid;
  task automatic cmp(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [2:0] exp_op(logic [2:0] op, bit rf);
    if (rf && op == CACHE_OP_LOAD) return CACHE_OP_LOAD_REFILL;
    if (rf && op == CACHE_OP_STORE) return CACHE_OP_STORE_REFILL;
    return op;
  endfunction
  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_cr = '{16, 16, 16};
      m_rob = '{0, 0, 0};
      m_dv = 0; m_rv = 0; m_dch = 0; m_dop = 0; m_drob = 0; m_dwb = 0; m_did = 0; m_rid = 0;
    end else begin
      macc = bus.enq_valid && mq.size() < 8;
      mk = -1;
      for (int i = 0; i < mq.size(); i++) if (mk < 0 && !mq[i].wt && m_cr[mq[i].ch] > 0) mk = i;
      mld = (!m_dv || bus.d_ready) && mk >= 0;
      m_rv = m_dv && bus.d_ready;
      if (m_rv) m_rid = m_did;
      if (mld) begin
        mch = mq[mk].ch;
        m_dv = 1;
        m_dch = 3'(1 << mch);
        m_drob = 4'(m_rob[mch]);
        m_dop = exp_op(mq[mk].op, mq[mk].rf);
        m_did = mq[mk].id;
        m_dwb = mq[mk].wb;
        m_cr[mch]--;
        m_rob[mch] = (m_rob[mch] + 1) % 16;
        mq.delete(mk);
      end else if (bus.d_ready) m_dv = 0;
      for (int c = 0; c < 3; c++) if (bus.crdt_rtn[c]) m_cr[c]++;
      for (int i = 0; i < mq.size(); i++)
        if (bus.wake_valid && mq[i].wt && mq[i].id == bus.wake_id) begin
          mq[i].wt = 0;
          mq[i].rf = 1;
        end
      if (macc) begin
        ne.ch = 0;
        for (int c = 0; c < 3; c++) if (bus.enq_ch_1hot[c]) ne.ch = c;
        ne.op = bus.enq_op;
        ne.id = bus.enq_id;
        ne.wb = bus.enq_wbuf_id;
        ne.rf = bus.enq_inflight && bus.wake_valid && bus.wake_id == bus.enq_id;
        ne.wt = bus.enq_inflight && !ne.rf;
        mq.push_back(ne);
      end
    end
  end
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("enq_ready", 32'(bus.enq_ready), 32'(mq.size() < 8));
      cmp("d_valid", 32'(bus.d_valid), 32'(m_dv));
      cmp("d_ch", 32'(bus.d_ch_1hot), 32'(m_dch));
      cmp("d_rob_id", 32'(bus.d_rob_id), 32'(m_drob));
      cmp("d_op", 32'(bus.d_op), 32'(m_dop));
      cmp("d_set", 32'(bus.d_set), 32'(m_did[5:0]));
      cmp("d_way", 32'(bus.d_way), 32'(m_did[9:6]));
      cmp("d_wbuf", 32'(bus.d_wbuf_id), 32'(m_dwb));
      cmp("rel_valid", 32'(bus.rel_valid), 32'(m_rv));
      if (m_rv) cmp("rel_id", 32'(bus.rel_id), 32'(m_rid));
    end
  end
  task automatic tick();
    @(posedge clk);
    #2;
  endtask
  task automatic enq(logic [2:0] ch, logic [2:0] op, logic [9:0] id, logic [3:0] wb, logic infl);
    int n;
    n = 0;
    while (!bus.enq_ready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) cmp("enq_ready_timeout", 32'(bus.enq_ready), 32'd1);
    else begin
      bus.enq_valid = 1; bus.enq_ch_1hot = ch; bus.enq_op = op; bus.enq_id = id;
      bus.enq_wbuf_id = wb; bus.enq_inflight = infl;
      tick();
      bus.enq_valid = 0; bus.enq_inflight = 0;
    end
  endtask
  task automatic wait_dv(int lim, output bit ok);
    ok = 0;
    for (int i = 0; i < lim && !ok; i++) begin
      if (bus.d_valid) ok = 1;
      else tick();
    end
  endtask
  task automatic watch(int n, output bit seen);
    seen = 0;
    for (int i = 0; i < n; i++) begin
      if (bus.d_valid) seen = 1;
      tick();
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    bit ok, s2, s17;
    int n;
    bus.enq_valid = 0; bus.enq_ch_1hot = 0; bus.enq_op = 0; bus.enq_id = 0; bus.enq_wbuf_id = 0;
    bus.enq_inflight = 0; bus.wake_valid = 0; bus.wake_id = 0; bus.crdt_rtn = 0; bus.d_ready = 0;
    rst = 1;
    tick();
    tick();
    rst = 0;
    chk_en = 1;
    cmp("rst_d_valid", 32'(bus.d_valid), 32'd0);
    cmp("rst_enq_ready", 32'(bus.enq_ready), 32'd1);
    cmp("rst_rel_valid", 32'(bus.rel_valid), 32'd0);
    // single load
    enq(3'b001, CACHE_OP_LOAD, 10'h041, 4'h3, 0);
    cmp("t1_not_yet", 32'(bus.d_valid), 32'd0);
    tick();
    cmp("t1_d_valid", 32'(bus.d_valid), 32'd1);
    cmp("t1_set", 32'(bus.d_set), 32'h01);
    cmp("t1_way", 32'(bus.d_way), 32'h1);
    cmp("t1_rob", 32'(bus.d_rob_id), 32'd0);
    cmp("t1_op", 32'(bus.d_op), 32'(CACHE_OP_LOAD));
    cmp("t1_wbuf", 32'(bus.d_wbuf_id), 32'h3);
    bus.d_ready = 1;
    tick();
    cmp("t1_rel_valid", 32'(bus.rel_valid), 32'd1);
    cmp("t1_rel_id", 32'(bus.rel_id), 32'h041);
    cmp("t1_dv_drop", 32'(bus.d_valid), 32'd0);
    bus.d_ready = 0;
    tick();
    cmp("t1_rel_once", 32'(bus.rel_valid), 32'd0);
    // fill with output stalled, then drain in order
    for (int k = 0; k < 9; k++) enq(3'b100, CACHE_OP_LOAD, 10'(10'h0C0 + k), 4'(k), 0);
    cmp("t2_full", 32'(bus.enq_ready), 32'd0);
    cmp("t2_hold_set", 32'(bus.d_set), 32'd0);
    tick();
    cmp("t2_hold_set2", 32'(bus.d_set), 32'd0);
    cmp("t2_hold_rob", 32'(bus.d_rob_id), 32'd0);
    bus.d_ready = 1;
    n = 0;
    for (int i = 0; i < 30; i++) begin
      if (bus.d_valid) begin
        cmp("t2_drain_rob", 32'(bus.d_rob_id), 32'(n));
        cmp("t2_drain_set", 32'(bus.d_set), 32'(n));
        n++;
      end
      tick();
    end
    cmp("t2_drain_count", 32'(n), 32'd9);
    // exhaust ch1 credits; younger ch2 passes the stalled ch1 entry
    for (int k = 0; k < 16; k++) enq(3'b010, CACHE_OP_LOAD, 10'(10'h200 + k), 4'(k), 0);
    enq(3'b010, CACHE_OP_STORE, 10'h2F0, 4'h0, 0);
    enq(3'b100, CACHE_OP_LOAD, 10'h3F1, 4'h1, 0);
    s2 = 0;
    s17 = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.d_valid && bus.d_ch_1hot == 3'b100) s2 = 1;
      if (bus.d_valid && bus.d_ch_1hot == 3'b010 && bus.d_set == 6'h30) s17 = 1;
      tick();
    end
    cmp("t3_ch2_passes", 32'(s2), 32'd1);
    cmp("t3_ch1_stalled", 32'(s17), 32'd0);
    bus.crdt_rtn = 3'b010;
    tick();
    bus.crdt_rtn = 0;
    wait_dv(10, ok);
    cmp("t3_ret_issue", 32'(ok), 32'd1);
    cmp("t3_ret_ch", 32'(bus.d_ch_1hot), 32'b010);
    cmp("t3_ret_rob", 32'(bus.d_rob_id), 32'd0);
    cmp("t3_ret_way", 32'(bus.d_way), 32'hB);
    tick();
    // refill wait and wake
    enq(3'b001, CACHE_OP_STORE, 10'h0A3, 4'h5, 1);
    watch(10, ok);
    cmp("t4_blocked", 32'(ok), 32'd0);
    bus.wake_valid = 1;
    bus.wake_id = 10'h0A3;
    tick();
    bus.wake_valid = 0;
    wait_dv(10, ok);
    cmp("t4_woken", 32'(ok), 32'd1);
    cmp("t4_op", 32'(bus.d_op), 32'(CACHE_OP_STORE_REFILL));
    cmp("t4_set", 32'(bus.d_set), 32'h23);
    cmp("t4_way", 32'(bus.d_way), 32'h2);
    tick();
    // same-cycle enq and wake, then a wake for another line
    bus.wake_valid = 1;
    bus.wake_id = 10'h155;
    enq(3'b001, CACHE_OP_LOAD, 10'h155, 4'h2, 1);
    bus.wake_valid = 0;
    tick();
    cmp("t5_dv", 32'(bus.d_valid), 32'd1);
    cmp("t5_op", 32'(bus.d_op), 32'(CACHE_OP_LOAD_REFILL));
    tick();
    enq(3'b001, CACHE_OP_LOAD, 10'h1AA, 4'h0, 1);
    bus.wake_valid = 1;
    bus.wake_id = 10'h1AB;
    tick();
    bus.wake_valid = 0;
    watch(6, ok);
    cmp("t5_other_wake", 32'(ok), 32'd0);
    // reset mid-operation
    bus.d_ready = 0;
    for (int k = 0; k < 5; k++) enq(3'b001, CACHE_OP_LOAD, 10'(10'h010 + k), 4'(k), 0);
    cmp("t6_dv_before", 32'(bus.d_valid), 32'd1);
    rst = 1;
    tick();
    rst = 0;
    cmp("t6_dv", 32'(bus.d_valid), 32'd0);
    cmp("t6_ready", 32'(bus.enq_ready), 32'd1);
    cmp("t6_rel", 32'(bus.rel_valid), 32'd0);
    cmp("t6_set", 32'(bus.d_set), 32'd0);
    bus.d_ready = 1;
    enq(3'b010, CACHE_OP_LOAD, 10'h001, 4'h0, 0);
    cmp("t6_ch1_credit_rel", 32'(bus.rel_valid), 32'd0);
    tick();
    cmp("t6_ch1_issue", 32'(bus.d_valid), 32'd1);
    cmp("t6_ch1_rob", 32'(bus.d_rob_id), 32'd0);
    enq(3'b001, CACHE_OP_LOAD, 10'h002, 4'h0, 0);
    tick();
    cmp("t6_ch0_issue", 32'(bus.d_valid), 32'd1);
    cmp("t6_ch0_rob", 32'(bus.d_rob_id), 32'd0);
    tick();
    bus.wake_valid = 1;
    bus.wake_id = 10'h1AA;
    tick();
    bus.wake_valid = 0;
    watch(5, ok);
    cmp("t6_waiter_gone", 32'(ok), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
